// File: rtl/fd_decode_reg.sv
// fd_decode_reg: fetch/decode pipeline register with valid/ready handshake.
// Decodes register selects and class flags; raw fields are latched verbatim.
`default_nettype none

module fd_decode_reg #(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_shamt,
  output logic [4:0]      out_aluop,
  output logic [16:0]     out_imm17,
  output logic [26:0]     out_target,
  output logic [4:0]      out_readA,
  output logic [4:0]      out_readB,
  output logic [4:0]      out_writeReg,
  output logic            out_we,
  output logic            out_is_rtype,
  output logic            out_is_imm,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_is_illegal
);

  localparam logic [4:0] c_OP_RTYPE = 5'b00000;
  localparam logic [4:0] c_OP_J     = 5'b00001;
  localparam logic [4:0] c_OP_BNE   = 5'b00010;
  localparam logic [4:0] c_OP_JAL   = 5'b00011;
  localparam logic [4:0] c_OP_JR    = 5'b00100;
  localparam logic [4:0] c_OP_ADDI  = 5'b00101;
  localparam logic [4:0] c_OP_BLT   = 5'b00110;
  localparam logic [4:0] c_OP_SW    = 5'b00111;
  localparam logic [4:0] c_OP_LW    = 5'b01000;
  localparam logic [4:0] c_OP_SETX  = 5'b10101;
  localparam logic [4:0] c_OP_BEX   = 5'b10110;
  localparam logic [4:0] c_REG_RA   = 5'd31;
  localparam logic [4:0] c_REG_RSTATUS = 5'd30;

  logic [4:0] w_op, w_rd, w_rs, w_rt;
  logic       w_load;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc_q;
  logic [4:0]      ra_q, ra_d, rb_q, rb_d, wr_q, wr_d;
  logic            we_q, we_d, rtype_q, rtype_d, imm_q, imm_d;
  logic            br_q, br_d, jmp_q, jmp_d, ill_q, ill_d;

  assign w_op = in_instr[31:27];
  assign w_rd = in_instr[26:22];
  assign w_rs = in_instr[21:17];
  assign w_rt = in_instr[16:12];

  always_comb begin
    ra_d    = '0;
    rb_d    = '0;
    wr_d    = '0;
    we_d    = 1'b0;
    rtype_d = 1'b0;
    imm_d   = 1'b0;
    br_d    = 1'b0;
    jmp_d   = 1'b0;
    ill_d   = 1'b0;
    case (w_op)
      c_OP_RTYPE: begin
        ra_d = w_rs; rb_d = w_rt; wr_d = w_rd; we_d = 1'b1; rtype_d = 1'b1;
      end
      c_OP_ADDI, c_OP_LW: begin
        ra_d = w_rs; wr_d = w_rd; we_d = 1'b1; imm_d = 1'b1;
      end
      c_OP_SW: begin
        ra_d = w_rs; rb_d = w_rd; imm_d = 1'b1;
      end
      // Branches compare rd against rs, hence the swapped read ports.
      c_OP_BNE, c_OP_BLT: begin
        ra_d = w_rd; rb_d = w_rs; br_d = 1'b1; imm_d = 1'b1;
      end
      c_OP_J:    jmp_d = 1'b1;
      c_OP_JAL: begin
        wr_d = c_REG_RA; we_d = 1'b1; jmp_d = 1'b1;
      end
      c_OP_JR: begin
        ra_d = w_rd; jmp_d = 1'b1;
      end
      c_OP_BEX: begin
        ra_d = c_REG_RSTATUS; br_d = 1'b1;
      end
      c_OP_SETX: begin
        wr_d = c_REG_RSTATUS; we_d = 1'b1;
      end
      default:   ill_d = 1'b1;
    endcase
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign w_load   = in_valid && in_ready;

  // Flush already blocks w_load through in_ready, so it only needs to clear valid.
  always_comb begin
    if (flush)          valid_d = 1'b0;
    else if (w_load)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = valid_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      rtype_q <= 1'b0;
      imm_q   <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (w_load) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
        ra_q    <= ra_d;
        rb_q    <= rb_d;
        wr_q    <= wr_d;
        we_q    <= we_d;
        rtype_q <= rtype_d;
        imm_q   <= imm_d;
        br_q    <= br_d;
        jmp_q   <= jmp_d;
        ill_q   <= ill_d;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_opcode     = instr_q[31:27];
  assign out_target     = instr_q[26:0];
  assign out_imm17      = instr_q[16:0];
  assign out_shamt      = instr_q[11:7];
  assign out_aluop      = instr_q[6:2];
  assign out_readA      = ra_q;
  assign out_readB      = rb_q;
  assign out_writeReg   = wr_q;
  assign out_we         = we_q;
  assign out_is_rtype   = rtype_q;
  assign out_is_imm     = imm_q;
  assign out_is_branch  = br_q;
  assign out_is_jump    = jmp_q;
  assign out_is_illegal = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_fd_decode_reg.sv
// tb_fd_decode_reg: directed plus random stimulus against a queue-based
// reference model; a negedge monitor compares whatever the DUT presents.
`default_nettype none

module tb_fd_decode_reg;

  localparam int PC_W = 12;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_opcode, out_shamt, out_aluop;
  logic [16:0]     out_imm17;
  logic [26:0]     out_target;
  logic [4:0]      out_readA, out_readB, out_writeReg;
  logic            out_we, out_is_rtype, out_is_imm, out_is_branch, out_is_jump, out_is_illegal;

  int checks = 0;
  int failures = 0;

  fd_decode_reg #(.PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_shamt(out_shamt), .out_aluop(out_aluop),
    .out_imm17(out_imm17), .out_target(out_target),
    .out_readA(out_readA), .out_readB(out_readB), .out_writeReg(out_writeReg),
    .out_we(out_we), .out_is_rtype(out_is_rtype), .out_is_imm(out_is_imm),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .out_is_illegal(out_is_illegal)
  );

  always #5 clock = ~clock;

  logic [91:0] act;
  assign act = {out_pc, out_opcode, out_shamt, out_aluop, out_imm17, out_target,
                out_readA, out_readB, out_writeReg, out_we, out_is_rtype,
                out_is_imm, out_is_branch, out_is_jump, out_is_illegal};

  logic [4:0] ops [12] = '{5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd1,
                           5'd3, 5'd4, 5'd22, 5'd21, 5'd31};

  // Reference decoder: table of opcode number -> (readA, readB, write, flags).
  function automatic logic [91:0] model(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    int op, rd, rs, rt, ra, rb, wr;
    bit we, rty, im, br, jp, il;
    op = int'(ins[31:27]); rd = int'(ins[26:22]); rs = int'(ins[21:17]); rt = int'(ins[16:12]);
    ra = 0; rb = 0; wr = 0; we = 0; rty = 0; im = 0; br = 0; jp = 0; il = 0;
    case (op)
      0:     begin ra = rs; rb = rt; wr = rd; we = 1; rty = 1; end
      5, 8:  begin ra = rs; wr = rd; we = 1; im = 1; end
      7:     begin ra = rs; rb = rd; im = 1; end
      2, 6:  begin ra = rd; rb = rs; br = 1; im = 1; end
      1:     jp = 1;
      3:     begin wr = 31; we = 1; jp = 1; end
      4:     begin ra = rd; jp = 1; end
      22:    begin ra = 30; br = 1; end
      21:    begin wr = 30; we = 1; end
      default: il = 1;
    endcase
    return {pc, ins[31:27], ins[11:7], ins[6:2], ins[16:0], ins[26:0],
            ra[4:0], rb[4:0], wr[4:0], we, rty, im, br, jp, il};
  endfunction

  task automatic chk(input string nm, input logic [91:0] a, input logic [91:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Scoreboard: holds at most the one entry the DUT should be presenting.
  logic [91:0] sb [$];
  logic        exp_rdy;

  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      exp_rdy = !flush && (sb.size() == 0 || out_ready);
      chk("in_ready", {91'd0, in_ready}, {91'd0, exp_rdy});
      chk("out_valid", {91'd0, out_valid}, {91'd0, sb.size() != 0});
      if (out_valid && sb.size() != 0) begin
        chk("outputs", act, sb[0]);
        if (out_ready || flush) void'(sb.pop_front());
      end
      if (in_valid && exp_rdy) sb.push_back(model(in_instr, in_pc));
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input logic rdy, input logic fl);
    @(posedge clock);
    #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    return r;
  endfunction

  initial begin
    logic [31:0] w;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("reset_state", act, '0);
    chk("reset_ready", {90'd0, out_valid, in_ready}, {90'd0, 1'b0, 1'b1});

    // addi $3,$2,-5
    step(1, 32'h28C5FFFB, 12'h004, 1, 0);
    step(0, 32'h0, 12'h0, 1, 0);
    chk("addi_direct", {out_valid, out_opcode, out_writeReg, out_readA, out_imm17,
                        out_we, out_is_imm, out_pc, 63'd0},
                       {1'b1, 5'd5, 5'd3, 5'd2, 17'h1FFFB, 1'b1, 1'b1, 12'h004, 63'd0});

    // Back-to-back R-type stream.
    for (int i = 0; i < 3; i++) step(1, rand_instr(5'd0), 12'h010 + 12'(i * 4), 1, 0);
    step(0, 32'h0, 12'h0, 1, 0);

    // Stall with a pending word, then simultaneous consume and load.
    step(1, rand_instr(5'd0), 12'h100, 1, 0);
    w = rand_instr(5'd7);
    repeat (4) step(1, w, 12'h104, 0, 0);
    step(1, w, 12'h104, 1, 0);
    step(0, 32'h0, 12'h0, 1, 0);

    // Every listed opcode plus an illegal one.
    for (int i = 0; i < 12; i++) step(1, rand_instr(ops[i]), 12'(12'h200 + i * 4), 1, 0);
    step(0, 32'h0, 12'h0, 1, 0);

    // Flush with an entry held and fetch presenting a word.
    step(1, rand_instr(5'd3), 12'h300, 0, 0);
    step(1, rand_instr(5'd4), 12'h304, 0, 1);
    chk("flush_ready", {91'd0, in_ready}, 92'd0);
    step(0, 32'h0, 12'h0, 0, 0);
    chk("flush_valid", {91'd0, out_valid}, 92'd0);

    // Asynchronous reset in the middle of a stall.
    step(1, rand_instr(5'd22), 12'h400, 0, 0);
    step(0, 32'h0, 12'h0, 0, 0);
    step(0, 32'h0, 12'h0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {out_valid, act[90:0]}, '0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 1) != 0) ? ops[$urandom_range(0, 11)] : 5'($urandom);
      step(1'($urandom_range(0, 3) != 0), rand_instr(op), 12'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end
    step(0, 32'h0, 12'h0, 1, 0);
    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
